alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the combinational alu interface: accepts one operation request at a time over a valid/ready handshake and latches opcode and operands. Drives the alu's in/a/b ports with stable values for a per-opcode latency, then captures f. Returns the result and destination tag over a second valid/ready handshake to the writeback stage. Sits between decode/regfile-read and writeback in sim_cpu.

Parameters:
DATA_WIDTH, 16, operand/result width; must match the attached alu.
TAG_W, 3, width of the destination register tag carried through.
MUL_LAT, 2, cycles spent in EXEC for op 3'b010; legal range 1..15.
DIV_LAT, 4, cycles spent in EXEC for op 3'b011; legal range 1..15.

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_op  input  3  alu opcode (000 add, 001 sub, 010 mul, 011 div, 100 not, 101 xor, 110 or, 111 and).
req_a  input  DATA_WIDTH  operand a.
req_b  input  DATA_WIDTH  operand b.
req_tag  input  TAG_W  destination tag.
alu_in  output  3  opcode to the alu.
alu_a  output  DATA_WIDTH  operand a to the alu.
alu_b  output  DATA_WIDTH  operand b to the alu.
alu_f  input  DATA_WIDTH  alu result, combinational from alu_in/alu_a/alu_b.
rsp_valid  output  1  result present.
rsp_ready  input  1  writeback accepts result.
rsp_data  output  DATA_WIDTH  result.
rsp_tag  output  TAG_W  tag of the result.
rsp_div0  output  1  result came from div with b==0.

Behaviour:
- Reset (async, rst_n low): state=IDLE; alu_in/alu_a/alu_b=0; rsp_valid=0; rsp_data=0; rsp_tag=0; rsp_div0=0; latency counter=0. rst_n low mid-operation aborts the op; nothing is emitted.
- FSM states: IDLE, EXEC, RESP.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready). Combinational from state and rsp_ready only; never from req_valid.
- Accept: when req_valid && req_ready, register op/a/b/tag into alu_in/alu_a/alu_b/tag reg.
  - Load counter with 1 for ops 000,001,100,101,110,111; MUL_LAT for 010; DIV_LAT for 011.
  - Go to EXEC.
- EXEC: decrement counter each cycle. alu_* outputs stay constant for the whole EXEC interval. When counter==1:
  - capture rsp_data=alu_f, rsp_tag=tag reg, rsp_div0=0, set rsp_valid=1, go to RESP.
  - Exception, div with alu_b==0: rsp_data=all ones and rsp_div0=1; alu_f is ignored.
- RESP: rsp_valid and rsp_data/rsp_tag/rsp_div0 are held stable until rsp_ready.
  - rsp_ready && !req_valid: rsp_valid=0, go to IDLE.
  - rsp_ready && req_valid: back-to-back; accept the new request in the same cycle, rsp_valid=0, go to EXEC.
- Minimum request-to-rsp_valid latency: 2 cycles for single-cycle ops (accept edge, capture edge).
- Peak throughput: one op per (lat+1) cycles.
- In IDLE, alu_* hold their last values; rsp_data holds its last value with rsp_valid=0.
- Width: operands and results are truncated to DATA_WIDTH, exactly as the alu defines (mul keeps the low half, not/ignores b).
- req_valid in EXEC: ignored (req_ready=0); the requester must hold it.

Optional Feature:
ALU_ISSUE_FLAGS_EN.
- Defined: adds outputs rsp_zero (1) and rsp_neg (1), captured with rsp_data. rsp_zero = (result==0); rsp_neg = result MSB. For div-by-zero: rsp_zero=0, rsp_neg=1. Both reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package alu_pkg: opcode localparams ALU_ADD..ALU_AND (3'b000..3'b111); FSM state encoding (IDLE/EXEC/RESP, 2 bits); function op_latency(op) returning the counter load value.
- One sub-module alu_lat_cnt: 4-bit loadable down-counter with load/dec inputs and a last (count==1) output.
- The alu itself is instantiated by the parent, not inside this block.

Test Plan:
- Add: req op=000 a=0x0003 b=0x0004 tag=5 at cycle 0 -> rsp_valid rises cycle 2, rsp_data=0x0007, rsp_tag=5, rsp_div0=0.
- Mul latency: op=010 a=0x0100 b=0x0100, MUL_LAT=2 -> rsp_valid at cycle 3, rsp_data=0x0000 (truncated); alu_a/alu_b stable cycles 1-2.
- Div by zero: op=011 a=0x1234 b=0 -> rsp_data=0xFFFF, rsp_div0=1 after DIV_LAT+1 cycles; with ALU_ISSUE_FLAGS_EN, rsp_neg=1 and rsp_zero=0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_tag unchanged and req_ready=0 throughout; rsp_ready=1 -> rsp_valid drops next cycle.
- Back-to-back: in RESP with rsp_ready=1, present sub a=9 b=2 -> accepted same cycle (req_ready=1), next rsp_data=0x0007 two cycles later.
- Async reset: assert rst_n=0 mid-EXEC of a div -> rsp_valid=0, req_ready=1 after release, no stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU issue controller: opcode
//            encodings, FSM state encoding, counter width and the
//            per-opcode EXEC latency helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Opcode encodings understood by the attached combinational ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  // The latency counter is sized for the largest legal latency (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of EXEC cycles for an opcode.
  // mul_lat and div_lat come from the instantiating module's parameters.
  function automatic logic [CNT_W-1:0] op_latency(input logic [2:0] op,
                                                  input int mul_lat,
                                                  input int div_lat);
    logic [CNT_W-1:0] lat;
    case (op)
      ALU_MUL: lat = CNT_W'(mul_lat);
      ALU_DIV: lat = CNT_W'(div_lat);
      default: lat = CNT_W'(1);
    endcase
    return lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_lat_cnt.sv
// ============================================================================
// Module   : alu_lat_cnt
// Purpose  : Loadable 4-bit down-counter that times the EXEC interval of
//            the ALU issue controller. last_o flags the final EXEC cycle.
// Ports    : clk         clock, rising edge
//            rst_n       asynchronous active-low reset (count -> 0)
//            load_i      load load_val_i (has priority over dec_i)
//            load_val_i  value to load
//            dec_i       decrement by one (saturates at zero)
//            last_o      count == 1
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_lat_cnt
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Initiator for a combinational ALU. Accepts one request at a
//            time (valid/ready), holds opcode/operands stable on the ALU
//            inputs for a per-opcode latency, captures the ALU result and
//            returns it with its destination tag over a second valid/ready
//            handshake.
// Ports    : clk, rst_n                      clock / async active-low reset
//            req_valid/req_ready             request handshake
//            req_op/req_a/req_b/req_tag      request payload
//            alu_in/alu_a/alu_b              registered drive to the ALU
//            alu_f                           ALU result (combinational)
//            rsp_valid/rsp_ready             response handshake
//            rsp_data/rsp_tag/rsp_div0       response payload
//            rsp_zero/rsp_neg                result flags (optional)
// Options  : define ALU_ISSUE_FLAGS_EN to add the rsp_zero/rsp_neg outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_W      = 3,
  parameter int MUL_LAT    = 2,   // legal range 1..15
  parameter int DIV_LAT    = 4    // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0]      req_tag,
  // ALU side
  output logic [2:0]            alu_in,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0]      rsp_tag,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic                  rsp_zero,
  output logic                  rsp_neg,
`endif
  output logic                  rsp_div0
);

  state_e           state_q;
  logic [TAG_W-1:0] tag_q;

  logic                  accept;
  logic                  cnt_last;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] result;
  logic [CNT_W-1:0]      lat_val;

  // Ready depends only on state and rsp_ready so the requester may wait
  // for ready before raising valid without creating a combinational loop.
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  // Divide-by-zero is decided from the held ALU inputs; the ALU output is
  // not trusted for that case and is replaced by all ones.
  assign div_by_zero = (alu_in == ALU_DIV) && (alu_b == '0);
  assign result      = div_by_zero ? '1 : alu_f;

  assign lat_val = op_latency(req_op, MUL_LAT, DIV_LAT);

  alu_lat_cnt u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (lat_val),
    .dec_i      (state_q == ST_EXEC),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tag_q     <= '0;
      alu_in    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_div0  <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
      rsp_zero  <= 1'b0;
      rsp_neg   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            alu_in  <= req_op;
            alu_a   <= req_a;
            alu_b   <= req_b;
            tag_q   <= req_tag;
            state_q <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (cnt_last) begin
            rsp_data  <= result;
            rsp_tag   <= tag_q;
            rsp_div0  <= div_by_zero;
`ifdef ALU_ISSUE_FLAGS_EN
            // All-ones substitution on div-by-zero yields zero=0, neg=1.
            rsp_zero  <= (result == '0);
            rsp_neg   <= result[DATA_WIDTH-1];
`endif
            rsp_valid <= 1'b1;
            state_q   <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (req_valid) begin
              // Back-to-back: the next op is taken in the retire cycle.
              alu_in  <= req_op;
              alu_a   <= req_a;
              alu_b   <= req_b;
              tag_q   <= req_tag;
              state_q <= ST_EXEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int DW      = 16;
  localparam int TW      = 3;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic [TW-1:0] req_tag;
  logic [2:0]    alu_in;
  logic [DW-1:0] alu_a, alu_b, alu_f;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_div0;
`ifdef ALU_ISSUE_FLAGS_EN
  logic          rsp_zero, rsp_neg;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_WIDTH (DW),
    .TAG_W      (TW),
    .MUL_LAT    (MUL_LAT),
    .DIV_LAT    (DIV_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .alu_in    (alu_in),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
`ifdef ALU_ISSUE_FLAGS_EN
    .rsp_zero  (rsp_zero),
    .rsp_neg   (rsp_neg),
`endif
    .rsp_div0  (rsp_div0)
  );

  // Environment ALU; on divide-by-zero it returns a junk pattern that the
  // controller is expected to override.
  always_comb begin
    alu_f = '0;
    case (alu_in)
      3'b000: alu_f = alu_a + alu_b;
      3'b001: alu_f = alu_a - alu_b;
      3'b010: alu_f = alu_a * alu_b;
      3'b011: alu_f = (alu_b == '0) ? 16'h5A5A : alu_a / alu_b;
      3'b100: alu_f = ~alu_a;
      3'b101: alu_f = alu_a ^ alu_b;
      3'b110: alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          div0;
    logic          zero;
    logic          neg;
    int            rise;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   bp_mode  = 3;   // 0: ready=1, 1: random, 3: driven by main
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result from the opcode definitions, latency in cycles
  // from the acceptance cycle.
  function automatic exp_t make_exp(input logic [2:0] op, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b, input logic [TW-1:0] tag,
                                    input int acc);
    exp_t e;
    int   lat;
    longint unsigned ua, ub;
    ua = a; ub = b;
    e.op = op; e.a = a; e.b = b; e.tag = tag; e.div0 = 1'b0;
    case (op)
      3'b000: e.data = DW'((ua + ub) % 65536);
      3'b001: e.data = DW'((ua + 65536 - ub) % 65536);
      3'b010: e.data = DW'((ua * ub) % 65536);
      3'b011: begin
        if (ub == 0) begin e.data = 16'hFFFF; e.div0 = 1'b1; end
        else e.data = DW'(ua / ub);
      end
      3'b100: e.data = DW'(65535 - ua);
      3'b101: e.data = a ^ b;
      3'b110: e.data = a | b;
      default: e.data = a & b;
    endcase
    e.zero = (e.data == 0) && !e.div0;
    e.neg  = e.data[DW-1];
    lat = (op == 3'b010) ? MUL_LAT : (op == 3'b011) ? DIV_LAT : 1;
    e.rise = acc + lat + 1;
    return e;
  endfunction

  // Drive one request and hold it until accepted; returns cycles waited.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag, output int waited);
    int acc;
    logic ok;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    waited = 0; ok = 1'b0; acc = 0;
    while (!ok && waited <= 300) begin
      @(negedge clk);
      if (req_ready) begin
        ok  = 1'b1;
        acc = cyc;
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      check("accept_timeout", 32'(waited), 32'd0);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      q.push_back(make_exp(op, a, b, tag, acc));
      req_valid = 1'b0;
      req_op = 3'($urandom); req_a = DW'($urandom); req_b = DW'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    logic done;
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) done = 1'b1;
      n++;
    end
    if (!done) check("drain_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    if (n >= 50) check("rsp_valid_timeout", 32'(n), 32'd0);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_valid) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: got data %h tag %h expected no response", rsp_data, rsp_tag);
          end else begin
            check("rsp_data", 32'(rsp_data), 32'(q[0].data));
            check("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
            check("rsp_div0", 32'(rsp_div0), 32'(q[0].div0));
`ifdef ALU_ISSUE_FLAGS_EN
            check("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
            check("rsp_neg", 32'(rsp_neg), 32'(q[0].neg));
`endif
            if (!prev_valid) check("latency", 32'(cyc), 32'(q[0].rise));
            check("req_ready_resp", 32'(req_ready), 32'(rsp_ready));
            if (rsp_ready) void'(q.pop_front());
          end
        end else begin
          if (q.size() == 0) begin
            check("req_ready_idle", 32'(req_ready), 32'd1);
          end else begin
            check("req_ready_exec", 32'(req_ready), 32'd0);
            check("alu_in_hold", 32'(alu_in), 32'(q[0].op));
            check("alu_a_hold", 32'(alu_a), 32'(q[0].a));
            check("alu_b_hold", 32'(alu_b), 32'(q[0].b));
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // Response backpressure generator
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_mode == 1) rsp_ready = 1'($urandom);
      else if (bp_mode == 0) rsp_ready = 1'b1;
    end
  end

  initial begin
    int w;
    logic [2:0]    op;
    logic [DW-1:0] a, b;

    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b1; bp_mode = 3; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_rsp_div0", 32'(rsp_div0), 32'd0);
    check("rst_alu_in", 32'(alu_in), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: add, truncated mul, div by zero
    bp_mode = 0;
    issue(3'b000, 16'h0003, 16'h0004, 3'd5, w); drain();
    issue(3'b010, 16'h0100, 16'h0100, 3'd1, w); drain();
    issue(3'b011, 16'h1234, 16'h0000, 3'd2, w); drain();

    // Backpressure: response held five cycles, then released
    bp_mode = 3; rsp_ready = 1'b0;
    issue(3'b101, 16'hF0F0, 16'h0FF0, 3'd7, w);
    wait_valid();
    repeat (5) @(negedge clk);
    check("bp_valid_held", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    drain();

    // Back-to-back: new request accepted in the retire cycle
    rsp_ready = 1'b0;
    issue(3'b000, 16'h0001, 16'h0001, 3'd3, w);
    wait_valid();
    @(posedge clk); #1; rsp_ready = 1'b1;
    issue(3'b001, 16'd9, 16'd2, 3'd6, w);
    check("b2b_same_cycle", 32'(w), 32'd0);
    drain();

    // Randomized traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = 3'($urandom);
      a  = DW'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      issue(op, a, b, 3'($urandom), w);
    end
    drain();

    // Async reset in the middle of a divide: nothing may be emitted
    bp_mode = 0;
    issue(3'b011, 16'd100, 16'd7, 3'd4, w);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_alu_in", 32'(alu_in), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
